// File: rtl/flow_table_arb.sv
// flow_table_arb
// Arbitrates a single-ported flow table between the datapath lookup
// requester and the configuration requester.
//   - Lookups normally win. A config request that has been blocked for
//     STARVE_MAX cycles takes the port.
//   - cfg_lock lets config hold the table exclusively for an atomic
//     multi-entry update, for at most LOCK_MAX cycles.
//   - Each grant's response is returned exactly one cycle later, tagged
//     to its owner.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   lk_req_*/lk_rsp_*   lookup request (valid/ready) and response (no backpressure)
//   cfg_req_*/cfg_rsp_* config request (valid/ready) and response / write ack
//   cfg_lock            config holds the table while high
//   mem_*               table RAM port; mem_rdata is valid one cycle after mem_en
//   locked              table is held by config
//   lock_timeout        sticky flag: a lock was forcibly released
module flow_table_arb #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_req_valid,
  input  logic [ADDR_W-1:0] lk_req_addr,
  output logic              lk_req_ready,
  output logic              lk_rsp_valid,
  output logic [DATA_W-1:0] lk_rsp_data,
  input  logic              cfg_req_valid,
  input  logic              cfg_req_we,
  input  logic [ADDR_W-1:0] cfg_req_addr,
  input  logic [DATA_W-1:0] cfg_req_wdata,
  input  logic              cfg_lock,
  output logic              cfg_req_ready,
  output logic              cfg_rsp_valid,
  output logic [DATA_W-1:0] cfg_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked,
  output logic              lock_timeout
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int LC_W = $clog2(LOCK_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);
  localparam logic [LC_W-1:0] LOCK_LAST  = LC_W'(LOCK_MAX - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [SC_W-1:0] starve_cnt;
  logic [LC_W-1:0] lock_cnt;
  logic            relock_block;  // set by a forced release, cleared once cfg_lock drops
  logic            rsp_valid;
  logic            rsp_is_cfg;
  logic            rsp_is_write;
  logic            starved;
  logic            lk_grant;
  logic            cfg_grant;
  logic            forced_exit;

  assign starved     = (starve_cnt == STARVE_TOP);
  assign lk_grant    = lk_req_valid & lk_req_ready;
  assign cfg_grant   = cfg_req_valid & cfg_req_ready;
  assign forced_exit = (state == LOCKED) & cfg_lock & (lock_cnt == LOCK_LAST);
  assign locked      = (state == LOCKED);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cfg_grant && cfg_lock && !relock_block) begin
          state_next = LOCKED;
        end else begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        // A grant in the releasing cycle still completes normally.
        if (!cfg_lock || (lock_cnt == LOCK_LAST)) begin
          state_next = IDLE;
        end else begin
          state_next = LOCKED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: request readiness (grant happens the same cycle as valid)
  always_comb begin
    lk_req_ready  = 1'b0;
    cfg_req_ready = 1'b0;
    if (rst) begin
      lk_req_ready  = 1'b0;
      cfg_req_ready = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Lookup has priority unless config has starved long enough.
          lk_req_ready  = !(starved && cfg_req_valid);
          cfg_req_ready = cfg_req_valid && (starved || !lk_req_valid);
        end
        LOCKED: begin
          lk_req_ready  = 1'b0;
          cfg_req_ready = cfg_req_valid;
        end
        default: begin
          lk_req_ready  = 1'b0;
          cfg_req_ready = 1'b0;
        end
      endcase
    end
  end

  // Table port is driven directly by whichever request is granted.
  assign mem_en    = lk_grant | cfg_grant;
  assign mem_we    = cfg_grant & cfg_req_we;
  assign mem_addr  = cfg_grant ? cfg_req_addr : lk_req_addr;
  assign mem_wdata = cfg_grant ? cfg_req_wdata : {DATA_W{1'b0}};

  // Count cycles a pending config request has been passed over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= {SC_W{1'b0}};
    end else if (!cfg_req_valid || cfg_grant) begin
      starve_cnt <= {SC_W{1'b0}};
    end else if (!starved) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Lock duration counter, sticky timeout flag and re-lock inhibit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt     <= {LC_W{1'b0}};
      lock_timeout <= 1'b0;
      relock_block <= 1'b0;
    end else begin
      // Zero while idle, so the first locked cycle sees zero.
      lock_cnt <= (state == LOCKED) ? (lock_cnt + LC_W'(1)) : {LC_W{1'b0}};
      if (forced_exit) begin
        lock_timeout <= 1'b1;
        relock_block <= 1'b1;
      end else if (!cfg_lock) begin
        relock_block <= 1'b0;
      end else begin
        relock_block <= relock_block;
      end
    end
  end

  // Response owner tracking: one-cycle latency, no backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_is_cfg   <= 1'b0;
      rsp_is_write <= 1'b0;
    end else begin
      rsp_valid    <= lk_grant | cfg_grant;
      rsp_is_cfg   <= cfg_grant;
      rsp_is_write <= cfg_grant & cfg_req_we;
    end
  end

  assign lk_rsp_valid  = rsp_valid & ~rsp_is_cfg;
  assign cfg_rsp_valid = rsp_valid & rsp_is_cfg;
  assign lk_rsp_data   = mem_rdata;
  assign cfg_rsp_rdata = rsp_is_write ? {DATA_W{1'b0}} : mem_rdata;

endmodule

// File: tb/tb_flow_table_arb.sv
// Testbench for flow_table_arb: random and directed stimulus checked
// cycle by cycle against a behavioural model of the arbitration rules.
module tb_flow_table_arb;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int LOCK_MAX   = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lk_req_valid = 1'b0;
  logic [ADDR_W-1:0] lk_req_addr = '0;
  logic              lk_req_ready;
  logic              lk_rsp_valid;
  logic [DATA_W-1:0] lk_rsp_data;
  logic              cfg_req_valid = 1'b0;
  logic              cfg_req_we = 1'b0;
  logic [ADDR_W-1:0] cfg_req_addr = '0;
  logic [DATA_W-1:0] cfg_req_wdata = '0;
  logic              cfg_lock = 1'b0;
  logic              cfg_req_ready;
  logic              cfg_rsp_valid;
  logic [DATA_W-1:0] cfg_rsp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              locked;
  logic              lock_timeout;

  flow_table_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .lk_req_valid(lk_req_valid), .lk_req_addr(lk_req_addr), .lk_req_ready(lk_req_ready),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_data(lk_rsp_data),
    .cfg_req_valid(cfg_req_valid), .cfg_req_we(cfg_req_we), .cfg_req_addr(cfg_req_addr),
    .cfg_req_wdata(cfg_req_wdata), .cfg_lock(cfg_lock), .cfg_req_ready(cfg_req_ready),
    .cfg_rsp_valid(cfg_rsp_valid), .cfg_rsp_rdata(cfg_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Table RAM: synchronous, one-cycle read latency, reloaded with known contents during reset.
  logic [DATA_W-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= seed_val(i);
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model state
  bit          m_locked, m_timeout, m_block, m_pend, m_pend_cfg;
  int          m_starve, m_lock_cycles;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [256];

  task automatic model_reset();
    m_locked = 0; m_timeout = 0; m_block = 0; m_pend = 0; m_pend_cfg = 0;
    m_starve = 0; m_lock_cycles = 0; m_pend_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
  endtask

  // One clock cycle: entered at a falling edge, drives inputs, checks, advances model, returns at next falling edge.
  task automatic step(input bit lv, input logic [7:0] la, input bit cv, input bit cwe,
                      input logic [7:0] ca, input logic [31:0] cwd, input bit lk);
    int win;  // 0 = nobody, 1 = lookup, 2 = config
    lk_req_valid = lv; lk_req_addr = la;
    cfg_req_valid = cv; cfg_req_we = cwe; cfg_req_addr = ca; cfg_req_wdata = cwd; cfg_lock = lk;
    if (m_locked) win = cv ? 2 : 0;
    else if (cv && (m_starve >= STARVE_MAX || !lv)) win = 2;
    else if (lv) win = 1;
    else win = 0;
    #2;
    check("lk_grant", 32'(lk_req_valid & lk_req_ready), 32'(win == 1));
    check("cfg_grant", 32'(cfg_req_valid & cfg_req_ready), 32'(win == 2));
    if (m_locked) check("lk_ready_locked", 32'(lk_req_ready), 32'd0);
    check("mem_en", 32'(mem_en), 32'(win != 0));
    check("mem_we", 32'(mem_we), 32'((win == 2) && cwe));
    if (win != 0) check("mem_addr", 32'(mem_addr), 32'((win == 2) ? ca : la));
    if (win == 2 && cwe) check("mem_wdata", mem_wdata, cwd);
    check("lk_rsp_valid", 32'(lk_rsp_valid), 32'(m_pend && !m_pend_cfg));
    check("cfg_rsp_valid", 32'(cfg_rsp_valid), 32'(m_pend && m_pend_cfg));
    if (m_pend && !m_pend_cfg) check("lk_rsp_data", lk_rsp_data, m_pend_data);
    if (m_pend && m_pend_cfg) check("cfg_rsp_rdata", cfg_rsp_rdata, m_pend_data);
    check("locked", 32'(locked), 32'(m_locked));
    check("lock_timeout", 32'(lock_timeout), 32'(m_timeout));
    // Effects of the coming rising edge
    m_pend = (win != 0);
    m_pend_cfg = (win == 2);
    if (win == 1) m_pend_data = ref_mem[la];
    else if (win == 2) m_pend_data = cwe ? 32'd0 : ref_mem[ca];
    if (win == 2 && cwe) ref_mem[ca] = cwd;
    if (cv && win != 2) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else m_starve = 0;
    if (!m_locked) begin
      if (win == 2 && lk && !m_block) begin
        m_locked = 1; m_lock_cycles = 0;
      end
    end else begin
      m_lock_cycles++;
      if (!lk) m_locked = 0;
      else if (m_lock_cycles == LOCK_MAX) begin
        m_locked = 0; m_timeout = 1; m_block = 1;
      end
    end
    if (!lk) m_block = 0;
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_lk_ready"}, 32'(lk_req_ready), 32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_req_ready), 32'd0);
    check({tag, "_lk_rsp_valid"}, 32'(lk_rsp_valid), 32'd0);
    check({tag, "_cfg_rsp_valid"}, 32'(cfg_rsp_valid), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_lock_timeout"}, 32'(lock_timeout), 32'd0);
  endtask

  // Reset asserted at a falling edge, held across one rising edge, released at the next falling edge.
  task automatic mid_reset();
    rst = 1'b1; lk_req_valid = 1'b1; cfg_req_valid = 1'b1; cfg_req_we = 1'b1; cfg_lock = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; lk_req_valid = 1'b0; cfg_req_valid = 1'b0; cfg_lock = 1'b0;
    model_reset();
  endtask

  initial begin
    bit hold;
    model_reset();
    lk_req_valid = 1'b1; cfg_req_valid = 1'b1; cfg_req_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("rst");
    rst = 1'b0; lk_req_valid = 1'b0; cfg_req_valid = 1'b0; cfg_req_we = 1'b0;

    // Both requesters continuously valid: L,L,L,L,C pattern
    for (int i = 0; i < 15; i++)
      step(1'b1, 8'($urandom), 1'b1, 1'($urandom), 8'($urandom), $urandom, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);

    // Config write followed immediately by lookup to the same address
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    check("write_then_lookup_mem", ref_mem[8'h10], 32'hDEAD_BEEF);

    // Locked multi-write while lookups keep requesting
    for (int i = 0; i < 14; i++)
      step(1'b1, 8'($urandom), i < 7, 1'b1, 8'($urandom_range(15)), $urandom, i < 9);

    // Lock held far past the limit, then re-lock only after cfg_lock toggles
    for (int i = 0; i < 100; i++)
      step((i > 0) && 1'($urandom), 8'($urandom_range(15)), (i == 0) || ($urandom_range(3) == 0),
           1'($urandom), 8'($urandom_range(15)), $urandom, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b0, 8'h00, 1'b1, 1'b1, 8'($urandom_range(15)), $urandom, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'h00, 1'b1, 1'($urandom), 8'($urandom_range(15)), $urandom, 1'b1);
    step(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);

    // Reset the cycle after a lookup grant: its response must vanish
    step(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    mid_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);

    // Random traffic with occasional lock episodes
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) hold = ~hold;
      step($urandom_range(9) < 7, 8'($urandom_range(15)), $urandom_range(9) < 4,
           1'($urandom), 8'($urandom_range(15)), $urandom, hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/flow_table_arb.md
FLOW_TABLE_ARB -- requirements
Module: flow_table_arb

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, flow table address width; DATA_W, 32, entry width; STARVE_MAX, 4, blocked cycles before config wins; LOCK_MAX, 64, maximum locked cycles.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- lk_req_valid  in  1  datapath lookup request
- lk_req_addr  in  ADDR_W  lookup address
- lk_req_ready  out  1  lookup accepted this cycle
- lk_rsp_valid  out  1  lookup result valid, no backpressure
- lk_rsp_data  out  DATA_W  lookup result
- cfg_req_valid  in  1  config request
- cfg_req_we  in  1  1=write, 0=read
- cfg_req_addr  in  ADDR_W  config address
- cfg_req_wdata  in  DATA_W  config write data
- cfg_lock  in  1  hold table for atomic multi-entry update
- cfg_req_ready  out  1  config request accepted this cycle
- cfg_rsp_valid  out  1  config read data / write ack
- cfg_rsp_rdata  out  DATA_W  config read data (0 on write ack)
- mem_en  out  1  table port enable
- mem_we  out  1  table write enable
- mem_addr  out  ADDR_W  table address
- mem_wdata  out  DATA_W  table write data
- mem_rdata  in  DATA_W  table read data, valid one cycle after mem_en
- locked  out  1  FSM in LOCKED
- lock_timeout  out  1  sticky, set when lock forcibly released

Function
REQ-003 At most one requester SHALL be granted per cycle; grant = valid && ready, same cycle.
REQ-004 mem_en/mem_we/mem_addr/mem_wdata SHALL be combinational from the granted request; mem_en=0, mem_we=0 when no grant.
REQ-005 FSM states SHALL be IDLE and LOCKED; reset state IDLE.
REQ-006 In IDLE, lookup SHALL have priority unless starve_cnt == STARVE_MAX, in which case a valid config request SHALL be granted and lookup ready held low.
REQ-007 starve_cnt SHALL increment each cycle cfg_req_valid=1 and not granted, saturate at STARVE_MAX, clear on config grant or cfg_req_valid=0.
REQ-008 IDLE -> LOCKED SHALL occur on a config grant with cfg_lock=1.
REQ-009 In LOCKED, lk_req_ready SHALL be 0 and cfg_req_ready SHALL equal cfg_req_valid.
REQ-010 LOCKED -> IDLE SHALL occur when cfg_lock=0 (checked every cycle, any grant that cycle still completes) or lock_cnt reaches LOCK_MAX-1.
REQ-011 lock_cnt SHALL clear on LOCKED entry and increment each LOCKED cycle; forced exit at LOCK_MAX SHALL set lock_timeout, which stays set until reset.
REQ-012 After a forced exit, re-entry to LOCKED SHALL require cfg_lock to drop low first.
REQ-013 A 1-bit owner tag and a valid bit SHALL be registered on each grant; next cycle the tagged response valid SHALL pulse for one cycle (latency exactly 1).
REQ-014 lk_rsp_data SHALL equal mem_rdata when lk_rsp_valid=1; cfg_rsp_rdata SHALL equal mem_rdata for reads, 0 for writes.
REQ-015 Lookups SHALL be read-only; lookup grants drive mem_we=0.
REQ-016 Back-to-back grants SHALL be supported every cycle with no bubble, including owner alternation.
REQ-017 A config write then a lookup to the same address in consecutive cycles SHALL return the new data.

Reset
REQ-018 While rst=1: FSM=IDLE, starve_cnt=0, lock_cnt=0, owner valid=0, lock_timeout=0, and lk_req_ready, cfg_req_ready, lk_rsp_valid, cfg_rsp_valid, mem_en, mem_we, locked all 0.
REQ-019 Reset asserted mid-transaction SHALL discard the pending response; no rsp_valid SHALL pulse in the cycle after rst deasserts.

Verification
REQ-020 Both valid continuously, STARVE_MAX=4 -> grants L,L,L,L,C repeating; each response 1 cycle after its grant, correct owner.
REQ-021 cfg write addr 0x10 data 0xDEADBEEF, next cycle lookup 0x10 -> cfg_rsp_valid with rdata 0, then lk_rsp_data=0xDEADBEEF.
REQ-022 cfg_lock=1 with 3 writes while lookups pending -> locked=1, lk_req_ready=0 throughout; cfg_lock=0 -> lookups resume next cycle.
REQ-023 cfg_lock held 100 cycles, LOCK_MAX=64 -> locked drops after 64 cycles, lock_timeout=1, no re-lock until cfg_lock toggles.
REQ-024 rst pulsed the cycle after a lookup grant -> no lk_rsp_valid, all outputs 0, FSM IDLE.
